// File: rtl/uart_rx_if.sv
// Byte output handshake of the UART receiver: the producer asserts rx_valid with rx_data,
// and the consumer accepts the byte with rx_ready.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8N1 at CLKS_PER_BIT clocks per bit, mid-bit sampling,
// single-register valid/ready output with frame-error and overrun pulses.
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1 and enables parity_err.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master out_if,
  output logic      frame_err,
  output logic      overrun,
  output logic      parity_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_e;

  logic          sync1_q, sync2_q;
  logic          rx_s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_c;
  logic          ovr_q, ovr_d;
  logic          done_c;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          perr_q, perr_c;
`endif

  assign rx_s = sync2_q;

  // Next-state, sampling and output-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    ferr_c  = 1'b0;
    done_c  = 1'b0;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_c  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            ferr_c  = 1'b1;
            state_d = WAIT_HIGH;
          end else begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit must have an even count of ones.
            if (^{sh_q, par_q}) perr_c = 1'b1;
            else                done_c = 1'b1;
`else
            done_c = 1'b1;
`endif
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (done_c) begin
      if (!valid_q || out_if.rx_ready) begin
        data_d  = sh_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_if.rx_ready) begin
      valid_d = 1'b0;
    end
  end

  // State, synchronizer and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_c;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_c;
`endif
    end
  end

  assign out_if.rx_data  = data_q;
  assign out_if.rx_valid = valid_q;
  assign frame_err       = ferr_q;
  assign overrun         = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err      = perr_q;
`else
  assign parity_err      = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver; the downstream counterpart of the byte-wide UART transmitter.
- Line format: 8N1 (start bit, 8 data bits LSB first, stop bit), fixed CLKS_PER_BIT system clocks per bit.
- Samples the asynchronous rx line at mid-bit and presents each received byte on a valid/ready output.
- Feeds the command/loopback logic or a receive FIFO.

Parameters:
CLKS_PER_BIT, 868, system clocks per bit (100 MHz / 115200); legal range 4..65535.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
rx  in  1  asynchronous serial line; idles high.
rx_data  out  8  received byte; stable while rx_valid is high.
rx_valid  out  1  byte available.
rx_ready  in  1  consumer accepts; transfer occurs on a cycle with rx_valid && rx_ready.
frame_err  out  1  one-cycle pulse: stop bit sampled low.
overrun  out  1  one-cycle pulse: completed byte dropped because the output was still occupied.
parity_err  out  1  one-cycle pulse; see Optional Feature. Tied to 0 when the feature is compiled out.

Behaviour:
- Reset:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, parity_err=0.
  - State=IDLE, bit counter=0, clock counter=0.
  - Both synchronizer flops set to 1.
  - Reset wins over all other events and aborts any frame in progress; no partial byte is ever output.
- Input sync: rx passes through 2 flops to give rx_s (2-cycle latency). Only rx_s is used.
- Definitions: H = CLKS_PER_BIT/2 (floor). T0 = first cycle with rx_s=0 while in IDLE.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on rx_s=0 go to START and clear the clock counter.
  - START: at T0+H, sample rx_s.
    - rx_s=1: false start, return to IDLE with no output.
    - rx_s=0: go to DATA and reload the clock counter.
  - DATA: sample bit i (i=0..7) at T0+H+(i+1)*CLKS_PER_BIT. Shift into the shift register LSB first. After bit 7, go to STOP.
  - STOP: sample at T0+H+9*CLKS_PER_BIT.
    - rx_s=1: byte complete, go to IDLE. A new start can be detected from the next cycle.
    - rx_s=0: frame_err pulses for 1 cycle, byte is discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a break condition from retriggering the receiver.
- Output latency: rx_valid rises on the cycle after the stop sample, i.e. T0+H+9*CLKS_PER_BIT+1.
- Output handshake (single output register):
  - Byte completes, rx_valid=0: load rx_data, set rx_valid=1.
  - Byte completes, rx_valid=1 and rx_ready=1 on the same cycle: old byte is transferred, new byte is loaded, rx_valid stays 1, no overrun.
  - Byte completes, rx_valid=1 and rx_ready=0: old byte is kept, new byte is dropped, overrun pulses for 1 cycle.
  - rx_valid && rx_ready with no completing byte: rx_valid=0 on the next cycle. rx_data holds its value.
- rx_data never changes while rx_valid=1, except on an accepted-and-replaced cycle.
- Error pulses are independent of rx_ready and are never held.
- Counter width: clog2(CLKS_PER_BIT). Counters must not wrap mid-bit.

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1: an even-parity bit follows data bit 7 and is sampled at T0+H+9*CLKS_PER_BIT.
  - The stop bit is sampled at T0+H+10*CLKS_PER_BIT, so rx_valid is delayed by one bit time.
  - Parity mismatch: parity_err pulses for 1 cycle in the same cycle the byte would have been delivered, and the byte is discarded.
  - If the frame also has a stop error, frame_err takes priority and parity_err is not asserted.
- Undefined: 8N1 as above; parity_err is constant 0.

Test Plan (CLKS_PER_BIT=16, rx_ready=1 unless stated):
- Send 0xA5 (8N1) -> rx_valid high for exactly 1 cycle, 2+8+144+1 = 155 cycles after the rx pin falls; rx_data=0xA5; no error pulses.
- rx pulsed low for 3 cycles, then high -> no rx_valid, no error pulses; then send 0x3C -> rx_data=0x3C received correctly.
- Send 0x81 with the stop bit driven low, rx held low for 40 cycles more, then high; then send 0x55 -> one frame_err pulse, no byte from the bad frame, one receive of 0x55.
- rx_ready=0; send 0x11 then 0x22 back-to-back -> rx_valid stays 1 with rx_data=0x11; one overrun pulse at the 0x22 stop sample; after rx_ready=1, one transfer of 0x11 and rx_valid=0.
- Assert rst for 1 cycle during data bit 4 of 0xF0, then send 0x0F -> no output from the aborted frame, all outputs 0 after reset, then rx_data=0x0F.
- With UART_RX_PARITY_EN: send 0x07 with parity 1 -> receive 0x07; send 0x07 with parity 0 -> parity_err pulse, no rx_valid.
